logic_basic_synchronizer_arbiter: RTL and testbench
===================================================

LOGIC_BASIC_SYNCHRONIZER_ARBITER -- requirements
Module: logic_basic_synchronizer_arbiter

Interface
REQ-001 The block SHALL have parameter REQUESTERS, default 4, number of asynchronous requesters (>=1).
REQ-002 The block SHALL have parameter STAGES, default 2, synchronizer flop stages per request line (>=2).
REQ-003 The block SHALL have parameter TIMEOUT, default 256, maximum grant hold in aclk cycles (>=1; used only with REQ-026).
REQ-004 The block SHALL define ID_WIDTH = max(1, clog2(REQUESTERS)).
REQ-005 aclk  input  1  clock; all state on rising edge.
REQ-006 areset_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  REQUESTERS  asynchronous 4-phase request per requester, any source domain.
REQ-008 ack  output  REQUESTERS  4-phase acknowledge per requester, registered.
REQ-009 grant  output  REQUESTERS  one-hot grant of the shared resource, registered.
REQ-010 grant_id  output  ID_WIDTH  binary index of the granted requester, valid while grant != 0.
REQ-011 done  input  1  aclk-domain single-cycle pulse from the resource ending the current grant.

Function
REQ-012 Each req bit SHALL pass through a STAGES-deep reset-to-0 flop chain; only synchronized values (sreq) SHALL be used internally.
REQ-013 The FSM SHALL have states IDLE, GRANT, RELEASE.
REQ-014 IDLE: when any sreq bit is 1, select the first set bit searching from index (last+1) mod REQUESTERS upward with wrap-around; next cycle grant[sel]=1, grant_id=sel, state GRANT.
REQ-015 IDLE with sreq all 0: stay IDLE, grant=0.
REQ-016 GRANT: hold grant unchanged until done=1; on that edge grant<=0, ack[sel]<=1, state RELEASE.
REQ-017 RELEASE: wait for sreq[sel]=0; on that edge ack[sel]<=0, last<=sel, state IDLE.
REQ-018 done SHALL be ignored in IDLE and RELEASE.
REQ-019 At most one grant bit and at most one ack bit SHALL be 1 in any cycle; grant and ack never both 1.
REQ-020 Latency: req rising at input -> grant high after STAGES+1 aclk edges when IDLE and no other contender.
REQ-021 Requester dropping req while in GRANT (protocol violation): grant SHALL still be held until done; RELEASE then completes after first cycle with sreq[sel]=0.
REQ-022 Back-to-back: a new selection SHALL occur at earliest the cycle after returning to IDLE (one idle cycle minimum between grants).
REQ-023 REQUESTERS=1: grant_id SHALL be constant 0; arbitration degenerates to single requester.

Reset
REQ-024 While areset_n=0: synchronizer flops, grant, ack = 0; grant_id = 0; state IDLE; last = REQUESTERS-1 (so index 0 has first priority).
REQ-025 Reset asserted mid-GRANT or mid-RELEASE SHALL clear outputs immediately (asynchronously); after release, arbitration restarts from IDLE using current sreq.

Configuration
REQ-026 Macro LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN defined: a counter SHALL run in GRANT; if done is not seen within TIMEOUT cycles of grant assertion, the block SHALL behave as if done=1 on cycle TIMEOUT and pulse output timeout (1 bit, reset 0) high for exactly that one cycle; done and timeout in the same cycle counts as done, no timeout pulse.
REQ-027 Macro undefined: no counter, no timeout port; grant held indefinitely until done.

Verification
REQ-028 Reset, REQUESTERS=4, STAGES=2; raise req[2] at cycle 0 -> grant=4'b0100, grant_id=2 at cycle 3; done at cycle 6 -> grant=0, ack[2]=1 at cycle 7; drop req[2] -> ack[2]=0 after 3 cycles.
REQ-029 req=4'b1111 held, each grant finished with done and each requester completing 4-phase -> grant order 0,1,2,3,0.
REQ-030 last=1, req=4'b1001 -> grant_id=3 (wrap search 2,3), then next grant_id=0.
REQ-031 done pulsed in IDLE and RELEASE -> no state or output change.
REQ-032 areset_n low during GRANT for req[1] -> grant=0, ack=0 same cycle; after release with req[1] still high -> grant_id=1 after STAGES+1 edges.
REQ-033 With TIMEOUT_EN, TIMEOUT=8, no done -> timeout=1 for one cycle 8 cycles after grant rise, ack[sel]=1 next cycle; without macro -> grant held >100 cycles.

Source files
------------

// File: rtl/logic_basic_synchronizer_arbiter.sv
// Round-robin arbiter for asynchronous 4-phase requesters, each synchronized into aclk.
// Optional grant-hold timeout enabled by defining LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN.
module logic_basic_synchronizer_arbiter #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned TIMEOUT    = 256,
  localparam int unsigned ID_WIDTH  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [REQUESTERS-1:0] req,
  output logic [REQUESTERS-1:0] ack,
  output logic [REQUESTERS-1:0] grant,
  output logic [ID_WIDTH-1:0]   grant_id,
`ifdef LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN
  output logic                  timeout,
`endif
  input  logic                  done
);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  logic [REQUESTERS-1:0] sync_q [STAGES];
  logic [REQUESTERS-1:0] sync_d [STAGES];
  logic [REQUESTERS-1:0] sreq;

  state_e                state_q, state_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [REQUESTERS-1:0] ack_q, ack_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;

  logic [ID_WIDTH-1:0]   pick;
  logic                  found;
  int unsigned           idx;
  logic                  end_grant;

  always_comb begin
    sync_d[0] = req;
    for (int unsigned s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign sreq = sync_q[STAGES-1];

  // Rotating priority: search starts just after the most recently served requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      idx = ({{(32-ID_WIDTH){1'b0}}, last_q} + 32'd1 + i) % REQUESTERS;
      if (!found && sreq[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

`ifdef LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // A registered timeout pulse ends the grant on the following edge; a real done wins.
  assign end_grant = done | timeout_q;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q == StGrant && !end_grant) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntW'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign end_grant = done;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = REQUESTERS'(1) << pick;
          id_d    = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (end_grant) begin
          grant_d = '0;
          ack_d   = REQUESTERS'(1) << id_q;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!sreq[id_q]) begin
          ack_d   = '0;
          last_d  = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ack_q   <= '0;
      id_q    <= '0;
      last_q  <= ID_WIDTH'(REQUESTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign grant_id = id_q;

endmodule

// File: tb/tb_logic_basic_synchronizer_arbiter.sv
// Directed bench for logic_basic_synchronizer_arbiter; expected grant order kept in a queue.
module tb_logic_basic_synchronizer_arbiter;

  logic       aclk;
  logic       areset_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       done;
`ifdef LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN
  logic       timeout;
`endif

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  logic_basic_synchronizer_arbiter #(
    .REQUESTERS(4),
    .STAGES    (2),
    .TIMEOUT   (8)
  ) dut (
    .aclk    (aclk),
    .areset_n(areset_n),
    .req     (req),
    .ack     (ack),
    .grant   (grant),
    .grant_id(grant_id),
`ifdef LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN
    .timeout (timeout),
`endif
    .done    (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    step(2);
    areset_n = 1'b1;
  endtask

  // Serve one grant through the full 4-phase handshake, checking against the queue head.
  task automatic serve(input bit rearm);
    int          n;
    int unsigned id;
    logic [3:0]  oh;
    n = 0;
    while (grant == 4'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("grant_seen", 32'(grant != 4'b0), 32'd1);
    chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
    id = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
    oh = 4'b0001 << id;
    chk("grant_id", 32'(grant_id), id);
    chk("grant_onehot", 32'(grant), 32'(oh));
    chk("ack_during_grant", 32'(ack), 32'd0);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("ack_set", 32'(ack), 32'(oh));
    chk("grant_clr", 32'(grant), 32'd0);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("ack_hold_release_done", 32'(ack), 32'(oh));
    req[id[1:0]] = 1'b0;
    n = 0;
    while (ack != 4'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("ack_drop", 32'(ack), 32'd0);
    chk("idle_gap", 32'(grant), 32'd0);
    if (rearm) req[id[1:0]] = 1'b1;
  endtask

  initial begin
    int n;
    req      = 4'b0;
    done     = 1'b0;
    areset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    step(2);
    areset_n = 1'b1;
    step(1);

    // Single requester timeline and latency
    req = 4'b0100;
    step(2);
    chk("latency_early", 32'(grant), 32'd0);
    step(1);
    chk("latency_grant", 32'(grant), 32'h4);
    chk("latency_id", 32'(grant_id), 32'd2);
    step(3);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("done_grant_clr", 32'(grant), 32'd0);
    chk("done_ack", 32'(ack), 32'h4);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("release_done_ignored", 32'(ack), 32'h4);
    req = 4'b0;
    step(2);
    chk("ack_still_high", 32'(ack), 32'h4);
    step(1);
    chk("ack_low_3cyc", 32'(ack), 32'd0);
    done = 1'b1;
    step(1);
    done = 1'b0;
    chk("idle_done_grant", 32'(grant), 32'd0);
    chk("idle_done_ack", 32'(ack), 32'd0);
    step(3);
    chk("idle_done_later", 32'(grant), 32'd0);

    // Round robin with all requesters active
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req = 4'b1111;
    repeat (5) serve(1'b1);
    req = 4'b0;

    // Wrap-around search from last=1
    do_reset();
    exp_q.push_back(1);
    req = 4'b0010;
    serve(1'b0);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req = 4'b1001;
    serve(1'b0);
    serve(1'b0);

    // Asynchronous reset mid-grant, then re-arbitration
    do_reset();
    req = 4'b0010;
    n = 0;
    while (grant == 4'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("pre_reset_grant", 32'(grant), 32'h2);
    areset_n = 1'b0;
    #1;
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_id", 32'(grant_id), 32'd0);
    step(1);
    areset_n = 1'b1;
    step(2);
    chk("post_rst_early", 32'(grant), 32'd0);
    step(1);
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_id", 32'(grant_id), 32'd1);

`ifdef LOGIC_BASIC_SYNCHRONIZER_ARBITER_TIMEOUT_EN
    step(7);
    chk("to_not_yet", 32'(timeout), 32'd0);
    chk("to_grant_held", 32'(grant), 32'h2);
    step(1);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_pulse_grant", 32'(grant), 32'h2);
    chk("to_pulse_ack", 32'(ack), 32'd0);
    step(1);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_ack", 32'(ack), 32'h2);
    chk("to_grant_clr", 32'(grant), 32'd0);
`else
    step(110);
    chk("hold_grant", 32'(grant), 32'h2);
    chk("hold_ack", 32'(ack), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
